msg_serializer: RTL and testbench
=================================

MSG_SERIALIZER -- requirements
Module: msg_serializer

Interface
REQ-001 SHALL have parameter MAX_MSG_BYTES, default 32: maximum message length in bytes.
REQ-002 SHALL have parameter DATA_BYTES, default 8: stream beat width in bytes.
REQ-003 SHALL have parameter TKEEP_WIDTH, default 8: m_tkeep width, equal to DATA_BYTES.
REQ-004 SHALL have port clk  input  1  the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port msg_data  input  8*MAX_MSG_BYTES  message; byte 0 in bits [7:0].
REQ-007 SHALL have port msg_len  input  $clog2(MAX_MSG_BYTES+1)  valid byte count.
REQ-008 SHALL have port msg_valid  input  1  message offered.
REQ-009 SHALL have port msg_error  input  1  message is marked errored.
REQ-010 SHALL have port msg_ready  output  1  message accepted when msg_valid and msg_ready are both high.
REQ-011 SHALL have port m_tvalid  output  1  AXI-Stream beat valid.
REQ-012 SHALL have port m_tready  input  1  downstream ready.
REQ-013 SHALL have port m_tdata  output  8*DATA_BYTES  beat data.
REQ-014 SHALL have port m_tkeep  output  TKEEP_WIDTH  byte qualifiers.
REQ-015 SHALL have port m_tlast  output  1  final beat of the message.
REQ-016 SHALL have port m_tuser  output  1  error flag, asserted on the final beat only.

Function
REQ-017 SHALL implement an FSM with states IDLE and SEND.
REQ-018 SHALL, in IDLE, drive msg_ready=1 and m_tvalid=0.
REQ-019 SHALL, on acceptance in cycle N, register msg_data, msg_len and msg_error, enter SEND, and assert m_tvalid in cycle N+1.
REQ-020 SHALL emit ceil(msg_len/DATA_BYTES) beats, taking bytes in ascending order, with byte 0 in m_tdata[7:0].
REQ-021 SHALL drive m_tkeep all-ones on non-final beats; on the final beat, the low (msg_len mod DATA_BYTES) bits are set, or all-ones if the remainder is 0.
REQ-022 SHALL drive to zero every m_tdata byte whose m_tkeep bit is 0.
REQ-023 SHALL assert m_tlast on the final beat only, and m_tuser = the registered msg_error on the final beat only (0 otherwise).
REQ-024 SHALL advance to the next beat only when m_tvalid and m_tready are both high.
REQ-025 SHALL hold m_tvalid, m_tdata, m_tkeep, m_tlast and m_tuser stable while m_tvalid=1 and m_tready=0.
REQ-026 SHALL return to IDLE after the final-beat handshake.
REQ-027 SHALL, for msg_len=0 or msg_len>MAX_MSG_BYTES, emit a single beat with m_tkeep=0, m_tdata=0, m_tlast=1 and m_tuser=1.
REQ-028 SHALL hold msg_ready=0 in SEND, except as allowed by REQ-033.
REQ-029 SHALL ignore msg_valid, msg_data and msg_error whenever msg_ready=0.

Reset
REQ-030 SHALL, on rst low, immediately force state=IDLE, m_tvalid=0, m_tlast=0, m_tuser=0, m_tkeep=0, m_tdata=0 and msg_ready=0, regardless of clk.
REQ-031 SHALL, on rst low mid-message, discard the in-flight message, and SHALL assert msg_ready in the first cycle after rst is released.

Configuration
REQ-032 SHALL recognise the macro MSG_SERIALIZER_BACK2BACK_EN.
REQ-033 SHALL, when MSG_SERIALIZER_BACK2BACK_EN is defined, drive msg_ready=1 in SEND during a final-beat handshake; a message accepted in that cycle starts its first beat next cycle, with no bubble.
REQ-034 SHALL, when MSG_SERIALIZER_BACK2BACK_EN is undefined, accept messages only in IDLE, giving at least one m_tvalid=0 cycle between messages.

Structure
REQ-035 SHALL take from shared package msg_pkg the state typedef, localparam MSG_BEATS_MAX=ceil(MAX_MSG_BYTES/DATA_BYTES) and the beat-index width constant.
REQ-036 SHALL instantiate sub-module msg_keep_gen, which maps a remaining-byte count to a contiguous low-aligned m_tkeep mask (combinational).

Verification
REQ-037 SHALL verify: msg_len=32, m_tready=1 -> 4 beats with m_tkeep=8'hFF, m_tlast only on beat 4, m_tuser=0.
REQ-038 SHALL verify: msg_len=13, msg_error=1 -> 2 beats; beat 2 has m_tkeep=8'h1F, bytes 5-7 zero, m_tlast=1 and m_tuser=1.
REQ-039 SHALL verify: msg_len=24 with m_tready low for 3 cycles on beat 2 -> beat 2 outputs held constant, and no beat skipped or repeated.
REQ-040 SHALL verify: msg_len=0 -> one beat with m_tkeep=0, m_tlast=1, m_tuser=1, then return to IDLE.
REQ-041 SHALL verify: rst low during beat 2 of a 32-byte message -> m_tvalid=0 immediately, msg_ready=1 one cycle after release, and no remnant beats.
REQ-042 SHALL verify: with MSG_SERIALIZER_BACK2BACK_EN defined, two 8-byte messages back to back -> m_tvalid high on consecutive cycles; without the macro, a one-cycle gap.

Source files
------------

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared state type and beat sizing for msg_serializer
package msg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int MAX_MSG_BYTES_DEF = 32;
  localparam int DATA_BYTES_DEF    = 8;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MSG_BEATS_MAX = ceil_div(MAX_MSG_BYTES_DEF, DATA_BYTES_DEF);
  localparam int BEAT_IDX_W    = idx_width(MSG_BEATS_MAX);

endpackage

// File: rtl/msg_serializer_if.sv
// rtl/msg_serializer_if.sv - message-in / stream-out bundle; master = serializer side
interface msg_serializer_if #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8,
  parameter int TKEEP_WIDTH   = 8
);
  localparam int LEN_W = $clog2(MAX_MSG_BYTES + 1);

  logic [8*MAX_MSG_BYTES-1:0] msg_data;
  logic [LEN_W-1:0]           msg_len;
  logic                       msg_valid;
  logic                       msg_error;
  logic                       msg_ready;

  logic                       m_tvalid;
  logic                       m_tready;
  logic [8*DATA_BYTES-1:0]    m_tdata;
  logic [TKEEP_WIDTH-1:0]     m_tkeep;
  logic                       m_tlast;
  logic                       m_tuser;

  modport master (
    input  msg_data, msg_len, msg_valid, msg_error, m_tready,
    output msg_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );

  modport slave (
    output msg_data, msg_len, msg_valid, msg_error, m_tready,
    input  msg_ready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );

endinterface

// File: rtl/msg_keep_gen.sv
// rtl/msg_keep_gen.sv - remaining-byte count to low-aligned keep mask, saturating at full beat
module msg_keep_gen #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 6
) (
  input  logic [CNT_W-1:0]      count,
  output logic [DATA_BYTES-1:0] keep
);

  always_comb begin
    keep = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep[i] = (32'(count) > 32'(i));
    end
  end

endmodule

// File: rtl/msg_serializer.sv
// rtl/msg_serializer.sv - message to stream-beat serializer; optional MSG_SERIALIZER_BACK2BACK_EN
module msg_serializer
  import msg_pkg::*;
#(
  parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEF,
  parameter int DATA_BYTES    = DATA_BYTES_DEF,
  parameter int TKEEP_WIDTH   = DATA_BYTES_DEF
) (
  input logic              clk,
  input logic              rst,
  msg_serializer_if.master bus
);

  localparam int LEN_W  = $clog2(MAX_MSG_BYTES + 1);
  localparam int BEATS  = ceil_div(MAX_MSG_BYTES, DATA_BYTES);
  localparam int IDX_W  = idx_width(BEATS);
  localparam int BEAT_W = 8 * DATA_BYTES;
  localparam int PAD_W  = BEATS * BEAT_W;

`ifdef MSG_SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [PAD_W-1:0]        data_q;
  logic [LEN_W-1:0]        rem_q;
  logic [IDX_W-1:0]        beat_q;
  logic                    err_q;
  logic                    bad_q;
  logic                    alive_q;

  logic                    ready;
  logic                    valid;
  logic                    accept;
  logic                    beat_done;
  logic                    last_beat;
  logic [DATA_BYTES-1:0]   keep_raw;
  logic [DATA_BYTES-1:0]   keep;
  logic [BEAT_W-1:0]       beat_data;

  msg_keep_gen #(
    .DATA_BYTES(DATA_BYTES),
    .CNT_W     (LEN_W)
  ) u_keep_gen (
    .count(rem_q),
    .keep (keep_raw)
  );

  // rem_q counts bytes still to send, so the current beat is final once it fits in one beat
  assign last_beat = bad_q || (32'(rem_q) <= 32'(DATA_BYTES));
  assign beat_data = data_q[32'(beat_q)*BEAT_W +: BEAT_W];
  assign accept    = ready && bus.msg_valid;
  assign beat_done = valid && bus.m_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = alive_q;
        if (alive_q && bus.msg_valid) state_d = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (bus.m_tready && last_beat) begin
          ready   = B2B;
          state_d = (B2B && bus.msg_valid) ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // alive_q keeps msg_ready low while reset is held and for the releasing edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        data_q <= PAD_W'(bus.msg_data);
        rem_q  <= bus.msg_len;
        beat_q <= '0;
        err_q  <= bus.msg_error;
        bad_q  <= (bus.msg_len == '0) || (32'(bus.msg_len) > 32'(MAX_MSG_BYTES));
      end else if (beat_done && !last_beat) begin
        rem_q  <= rem_q - LEN_W'(DATA_BYTES);
        beat_q <= beat_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    bus.msg_ready = ready;
    bus.m_tvalid  = valid;
    keep          = '0;
    bus.m_tdata   = '0;
    bus.m_tlast   = 1'b0;
    bus.m_tuser   = 1'b0;
    if (valid) begin
      keep        = bad_q ? '0 : keep_raw;
      bus.m_tlast = last_beat;
      bus.m_tuser = last_beat && (err_q || bad_q);
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (keep[i]) bus.m_tdata[8*i +: 8] = beat_data[8*i +: 8];
      end
    end
    bus.m_tkeep = keep;
  end

endmodule

// File: tb/tb_msg_serializer.sv
// tb/tb_msg_serializer.sv - table-driven scoreboard bench for msg_serializer
`timescale 1ns/1ps
module tb_msg_serializer;

  localparam int MAXB  = 32;
  localparam int DB    = 8;
  localparam int KW    = 8;
  localparam int LEN_W = $clog2(MAXB + 1);
`ifdef MSG_SERIALIZER_BACK2BACK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef struct {
    logic [8*DB-1:0] data;
    logic [KW-1:0]   keep;
    logic            last;
    logic            user;
  } beat_t;

  typedef struct {
    int       len;
    bit       err;
    bit       stall;
    int       exp_beats;
    logic [7:0] exp_keep;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msg_serializer_if #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB), .TKEEP_WIDTH(KW)) bus ();

  msg_serializer #(.MAX_MSG_BYTES(MAXB), .DATA_BYTES(DB), .TKEEP_WIDTH(KW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  beat_t sb[$];
  int    hs_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  logic [7:0] last_keep = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-wise reference: byte n of the message lands in beat n/DB, lane n%DB
  task automatic push_expected(input int len, input bit err, input logic [8*MAXB-1:0] data);
    beat_t b;
    int nb;
    if (len == 0 || len > MAXB) begin
      b.data = '0; b.keep = '0; b.last = 1'b1; b.user = 1'b1;
      sb.push_back(b);
      return;
    end
    nb = (len + DB - 1) / DB;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < DB; i++) begin
        if (k*DB + i < len) begin
          b.keep[i] = 1'b1;
          b.data[8*i +: 8] = data[8*(k*DB + i) +: 8];
        end
      end
      b.last = (k == nb - 1);
      b.user = b.last ? err : 1'b0;
      sb.push_back(b);
    end
  endtask

  task automatic send_msg(input int len, input bit err, input logic [8*MAXB-1:0] data);
    int  n = 0;
    bit  ok = 0;
    bus.msg_len   = LEN_W'(len);
    bus.msg_error = err;
    bus.msg_data  = data;
    bus.msg_valid = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      if (bus.msg_ready) begin
        ok = 1;
        break;
      end
      n++;
    end
    chk("msg_accepted", 64'(ok), 64'd1);
    if (ok) push_expected(len, err, data);
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    bus.msg_error = 1'b0;
  endtask

  task automatic wait_idle(input bit stall);
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.m_tvalid) break;
      @(posedge clk);
      #1;
      bus.m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("drain_in_time", 64'(n < 400), 64'd1);
    bus.m_tready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  beat_t exp_b;
  beat_t prev_b;
  logic  prev_hold = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_tdata", bus.m_tdata, prev_b.data);
        chk("hold_ctrl", {bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tkeep},
            {1'b1, prev_b.last, prev_b.user, prev_b.keep});
      end
      prev_hold   = bus.m_tvalid && !bus.m_tready;
      prev_b.data = bus.m_tdata;
      prev_b.keep = bus.m_tkeep;
      prev_b.last = bus.m_tlast;
      prev_b.user = bus.m_tuser;
      if (bus.m_tvalid && bus.m_tready) begin
        hs_cyc.push_back(cyc);
        beat_cnt++;
        last_keep = bus.m_tkeep;
        chk("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          chk("tdata", bus.m_tdata, exp_b.data);
          chk("tkeep", bus.m_tkeep, exp_b.keep);
          chk("tlast", bus.m_tlast, exp_b.last);
          chk("tuser", bus.m_tuser, exp_b.user);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];
  logic [8*MAXB-1:0] d;
  logic [8*MAXB-1:0] d2;
  logic [8*DB-1:0]   held;
  bit                remnant;

  initial begin
    vecs[0] = '{32, 1'b0, 1'b0, 4, 8'hFF};
    vecs[1] = '{13, 1'b1, 1'b0, 2, 8'h1F};
    vecs[2] = '{24, 1'b0, 1'b1, 3, 8'hFF};
    vecs[3] = '{1,  1'b0, 1'b0, 1, 8'h01};
    vecs[4] = '{8,  1'b1, 1'b1, 1, 8'hFF};
    vecs[5] = '{9,  1'b0, 1'b1, 2, 8'h01};
    vecs[6] = '{31, 1'b0, 1'b1, 4, 8'h7F};
    vecs[7] = '{0,  1'b0, 1'b0, 1, 8'h00};
    vecs[8] = '{40, 1'b0, 1'b0, 1, 8'h00};
    vecs[9] = '{7,  1'b1, 1'b0, 1, 8'h7F};

    bus.msg_valid = 1'b0;
    bus.msg_error = 1'b0;
    bus.msg_len   = '0;
    bus.msg_data  = '0;
    bus.m_tready  = 1'b1;

    #2;
    chk("rst_tvalid", bus.m_tvalid, 1'b0);
    chk("rst_msg_ready", bus.msg_ready, 1'b0);
    chk("rst_tdata", bus.m_tdata, '0);
    chk("rst_tkeep_last_user", {bus.m_tkeep, bus.m_tlast, bus.m_tuser}, '0);
    #20 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.msg_ready, 1'b1);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
      beat_cnt = 0;
      send_msg(vecs[v].len, vecs[v].err, d);
      wait_idle(vecs[v].stall);
      chk($sformatf("v%0d_beat_count", v), 64'(beat_cnt), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_last_keep", v), 64'(last_keep), 64'(vecs[v].exp_keep));
    end

    // Three stalled cycles on beat 2 of a 24-byte message
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    beat_cnt = 0;
    send_msg(24, 1'b0, d);
    @(posedge clk);
    #1;
    bus.m_tready = 1'b0;
    held = bus.m_tdata;
    chk("stall_b2_content", held, d[127:64]);
    repeat (3) begin
      @(negedge clk);
      chk("stall_b2_data", bus.m_tdata, held);
      chk("stall_b2_valid", bus.m_tvalid, 1'b1);
      @(posedge clk);
    end
    #1;
    bus.m_tready = 1'b1;
    wait_idle(1'b0);
    chk("stall_beat_count", 64'(beat_cnt), 64'd3);

    // Reset while beat 2 of a 32-byte message is on the bus
    for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
    beat_cnt = 0;
    send_msg(32, 1'b0, d);
    @(posedge clk);
    #1;
    chk("pre_rst_tvalid", bus.m_tvalid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tvalid", bus.m_tvalid, 1'b0);
    chk("mid_rst_msg_ready", bus.msg_ready, 1'b0);
    chk("mid_rst_outputs", {bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tuser}, '0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", bus.msg_ready, 1'b1);
    remnant = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m_tvalid) remnant = 1'b1;
    end
    chk("no_remnant_beats", remnant, 1'b0);
    chk("rst_beat_count", 64'(beat_cnt), 64'd1);
    @(posedge clk);
    #1;

    // Two 8-byte messages offered back to back
    for (int i = 0; i < MAXB; i++) begin
      d[8*i +: 8]  = 8'($urandom);
      d2[8*i +: 8] = 8'($urandom);
    end
    hs_cyc.delete();
    send_msg(8, 1'b0, d);
    send_msg(8, 1'b1, d2);
    wait_idle(1'b0);
    chk("b2b_handshakes", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() == 2) chk("b2b_beat_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'(GAP));

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
